// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of the instruction/data requester handshakes
// and the RAM port that mem_port_arbiter sits between.
//   slave  - the arbiter's view (requests and RAM read data in; grants,
//            refill beats and RAM address/write controls out)
//   master - the view of whatever drives the requests and models the RAM
interface mem_port_arbiter_if;
    // instruction-cache refill side
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_grant;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_done;

    // data-cache refill/store side
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_grant;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_done;

    // shared RAM port (combinational read, synchronous write)
    logic [31:0] mem_address;
    logic [31:0] mem_value;
    logic        mem_write;
    logic [31:0] mem_data;

    modport slave (
        input  i_req, i_addr,
        output i_grant, i_rvalid, i_rdata, i_done,
        input  d_req, d_we, d_addr, d_wdata,
        output d_grant, d_rvalid, d_rdata, d_done,
        output mem_address, mem_value, mem_write,
        input  mem_data
    );

    modport master (
        output i_req, i_addr,
        input  i_grant, i_rvalid, i_rdata, i_done,
        output d_req, d_we, d_addr, d_wdata,
        input  d_grant, d_rvalid, d_rdata, d_done,
        input  mem_address, mem_value, mem_write,
        output mem_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between the I-cache refill side and
// the D-cache refill/store side. Each transaction is a LINE_WORDS-beat
// aligned read burst or a single-word write, followed by one turnaround
// cycle before the port can be granted again.
//
// Optional build macro ARB_ROUND_ROBIN_EN: when defined, simultaneous
// requests alternate based on which side was granted last; when undefined
// the data side always wins a tie.
module mem_port_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 4
) (
    input  logic          clock,
    input  logic          reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_IBURST = 3'd1;
    localparam logic [2:0] S_DBURST = 3'd2;
    localparam logic [2:0] S_DWRITE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // byte-offset bits inside one line; clearing them gives the line base
    localparam int             OFF_W     = $clog2(LINE_WORDS * 4);
    localparam logic [31:0]    LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] beat;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;

    logic             i_grant_q, d_grant_q;
    logic             i_rvalid_q, d_rvalid_q;
    logic [31:0]      i_rdata_q, d_rdata_q;
    logic             i_done_q, d_done_q;

    logic             pick_i, pick_d;
    logic             start_i, start_d;
    logic             in_burst, last_beat;

    logic [31:0]      line_base;
    logic [31:0]      beat_off;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = data side held the most recent grant, 0 = instruction side
    logic             last_d;

    // a tie goes to whichever side was not served last
    always_comb begin
        pick_d = bus.d_req && (!bus.i_req || !last_d);
        pick_i = bus.i_req && !pick_d;
    end

    // remember the side of every grant so the next tie alternates
    always_ff @(posedge clock) begin
        if (reset)
            last_d <= 1'b0;
        else if (start_d)
            last_d <= 1'b1;
        else if (start_i)
            last_d <= 1'b0;
    end
`else
    // data side has fixed priority on a tie
    always_comb begin
        pick_d = bus.d_req;
        pick_i = bus.i_req && !bus.d_req;
    end
`endif

    assign start_d   = (state == S_IDLE) && pick_d;
    assign start_i   = (state == S_IDLE) && pick_i;
    assign in_burst  = (state == S_IBURST) || (state == S_DBURST);
    assign last_beat = in_burst && (beat == LAST_BEAT);

    // next-state selection; requests are only looked at in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pick_d)
                    state_nxt = bus.d_we ? S_DWRITE : S_DBURST;
                else if (pick_i)
                    state_nxt = S_IBURST;
            end
            S_IBURST, S_DBURST: begin
                if (beat == LAST_BEAT)
                    state_nxt = S_DONE;
            end
            S_DWRITE: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // state register and beat counter; counter rewinds on the last beat
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            if (in_burst)
                beat <= last_beat ? '0 : beat + 1'b1;
            else
                beat <= '0;
        end
    end

    // capture the winner's address and store data at grant time so later
    // changes on the request inputs cannot disturb a running transaction
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (start_d) begin
            addr_q  <= bus.d_addr;
            wdata_q <= bus.d_wdata;
        end else if (start_i) begin
            addr_q  <= bus.i_addr;
        end
    end

    // grants rise when leaving IDLE and fall on the turnaround edge
    always_ff @(posedge clock) begin
        if (reset) begin
            i_grant_q <= 1'b0;
            d_grant_q <= 1'b0;
        end else if (start_d) begin
            d_grant_q <= 1'b1;
        end else if (start_i) begin
            i_grant_q <= 1'b1;
        end else if (state == S_DONE) begin
            i_grant_q <= 1'b0;
            d_grant_q <= 1'b0;
        end
    end

    // instruction-side beats: registered copy of RAM data, one-cycle
    // rvalid per beat, done alongside the final rvalid
    always_ff @(posedge clock) begin
        if (reset) begin
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            i_done_q   <= 1'b0;
        end else begin
            i_rvalid_q <= (state == S_IBURST);
            i_done_q   <= (state == S_IBURST) && last_beat;
            if (state == S_IBURST)
                i_rdata_q <= bus.mem_data;
        end
    end

    // data-side beats and write completion
    always_ff @(posedge clock) begin
        if (reset) begin
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
            d_done_q   <= 1'b0;
        end else begin
            d_rvalid_q <= (state == S_DBURST);
            d_done_q   <= ((state == S_DBURST) && last_beat) ||
                          (state == S_DWRITE);
            if (state == S_DBURST)
                d_rdata_q <= bus.mem_data;
        end
    end

    assign line_base = addr_q & LINE_MASK;
    assign beat_off  = {{(30 - CNT_W){1'b0}}, beat, 2'b00};

    // RAM port drive; idle states park everything at zero and the write
    // enable is held off during reset so a reset cycle never writes
    always_comb begin
        bus.mem_address = '0;
        bus.mem_value   = '0;
        bus.mem_write   = 1'b0;
        case (state)
            S_IBURST, S_DBURST: begin
                bus.mem_address = line_base + beat_off;
            end
            S_DWRITE: begin
                bus.mem_address = {addr_q[31:2], 2'b00};
                bus.mem_value   = wdata_q;
                bus.mem_write   = !reset;
            end
            default: ;
        endcase
    end

    assign bus.i_grant  = i_grant_q;
    assign bus.i_rvalid = i_rvalid_q;
    assign bus.i_rdata  = i_rdata_q;
    assign bus.i_done   = i_done_q;
    assign bus.d_grant  = d_grant_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.d_done   = d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (LINE_WORDS=4). The RAM model returns
// 0xA0000000 | word_index for unwritten words and the stored value otherwise.
module tb_mem_port_arbiter;

    logic clock;
    logic reset;
    int   pass_cnt;
    int   total_cnt;
    int   wr_cnt;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.LINE_WORDS(4), .CNT_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM model: combinational read, synchronous write
    bit          wr_valid [256];
    logic [31:0] wr_data  [256];
    logic [7:0]  ram_idx;

    assign ram_idx      = bus.mem_address[9:2];
    assign bus.mem_data = wr_valid[ram_idx] ? wr_data[ram_idx]
                                            : (32'hA000_0000 | {24'd0, ram_idx});

    always @(posedge clock) begin
        if (bus.mem_write === 1'b1) begin
            wr_valid[ram_idx] <= 1'b1;
            wr_data[ram_idx]  <= bus.mem_value;
        end
    end

    always @(negedge clock)
        if (bus.mem_write === 1'b1) wr_cnt++;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // run until both sides are idle, dropping each request on its done pulse
    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.d_done === 1'b1) bus.d_req = 1'b0;
            if (bus.i_done === 1'b1) bus.i_req = 1'b0;
            if (!bus.i_req && !bus.d_req && bus.i_grant === 1'b0 && bus.d_grant === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bit ok;
        reset = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = 32'h0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0; bus.d_wdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            step();
            total_cnt++;
            if ({bus.i_grant, bus.d_grant, bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done,
                 bus.mem_write, bus.mem_address, bus.mem_value, bus.i_rdata, bus.d_rdata} !== '0)
                $display("FAIL reset_outputs cycle %0d: ig=%b dg=%b iv=%b dv=%b idn=%b ddn=%b we=%b addr=%h val=%h ird=%h drd=%h, required all 0",
                         c, bus.i_grant, bus.d_grant, bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done,
                         bus.mem_write, bus.mem_address, bus.mem_value, bus.i_rdata, bus.d_rdata);
            else pass_cnt++;
        end
        total_cnt++;
        if (wr_cnt !== 0) $display("FAIL reset_no_write: writes=%0d required 0", wr_cnt);
        else pass_cnt++;
        bus.d_we = 1'b0;
        reset = 1'b0;
        step();
        total_cnt++;
        if ({bus.i_grant, bus.d_grant} !== 2'b01)
            $display("FAIL reset_first_grant: {i,d}=%b required 01", {bus.i_grant, bus.d_grant});
        else pass_cnt++;
        drain(ok);
        total_cnt++;
        if (!ok) $display("FAIL reset_drain: timed out waiting for idle");
        else pass_cnt++;
    endtask

    task automatic test_contention;
        bit ok;
        bus.i_req = 1'b1; bus.i_addr = 32'h20;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        step();
        total_cnt++;
        if ({bus.i_grant, bus.d_grant, bus.mem_address} !== {2'b01, 32'h40})
            $display("FAIL tie1_grant: {i,d}=%b addr=%h required 01 addr=00000040",
                     {bus.i_grant, bus.d_grant}, bus.mem_address);
        else pass_cnt++;
        repeat (4) step();
        total_cnt++;
        if (bus.d_done !== 1'b1) $display("FAIL tie1_done: d_done=%b required 1", bus.d_done);
        else pass_cnt++;
        bus.d_req = 1'b0;
        step();
        total_cnt++;
        if ({bus.i_grant, bus.d_grant} !== 2'b00)
            $display("FAIL tie1_turnaround: {i,d}=%b required 00", {bus.i_grant, bus.d_grant});
        else pass_cnt++;
        bus.d_req = 1'b1; bus.d_addr = 32'h60;
        step();
`ifdef ARB_ROUND_ROBIN_EN
        total_cnt++;
        if ({bus.i_grant, bus.d_grant, bus.mem_address} !== {2'b10, 32'h20})
            $display("FAIL tie2_grant: {i,d}=%b addr=%h required 10 addr=00000020",
                     {bus.i_grant, bus.d_grant}, bus.mem_address);
        else pass_cnt++;
        repeat (4) step();
        bus.i_req = 1'b0;
        step();
        step();
        total_cnt++;
        if ({bus.i_grant, bus.d_grant, bus.mem_address} !== {2'b01, 32'h60})
            $display("FAIL tie2_next: {i,d}=%b addr=%h required 01 addr=00000060",
                     {bus.i_grant, bus.d_grant}, bus.mem_address);
        else pass_cnt++;
`else
        total_cnt++;
        if ({bus.i_grant, bus.d_grant, bus.mem_address} !== {2'b01, 32'h60})
            $display("FAIL tie2_grant: {i,d}=%b addr=%h required 01 addr=00000060",
                     {bus.i_grant, bus.d_grant}, bus.mem_address);
        else pass_cnt++;
        repeat (4) step();
        bus.d_req = 1'b0;
        step();
        total_cnt++;
        if ({bus.i_grant, bus.d_grant} !== 2'b00)
            $display("FAIL tie2_turnaround: {i,d}=%b required 00", {bus.i_grant, bus.d_grant});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({bus.i_grant, bus.d_grant, bus.mem_address} !== {2'b10, 32'h20})
            $display("FAIL tie2_next: {i,d}=%b addr=%h required 10 addr=00000020",
                     {bus.i_grant, bus.d_grant}, bus.mem_address);
        else pass_cnt++;
`endif
        drain(ok);
        total_cnt++;
        if (!ok) $display("FAIL tie_drain: timed out waiting for idle");
        else pass_cnt++;
    endtask

    task automatic test_burst;
        logic [31:0] exp_addr [4];
        int          gcnt;
        exp_addr[0] = 32'h14; exp_addr[1] = 32'h18; exp_addr[2] = 32'h1C; exp_addr[3] = 32'h0;
        bus.i_req = 1'b1; bus.i_addr = 32'h14;
        step();
        gcnt = (bus.i_grant === 1'b1) ? 1 : 0;
        total_cnt++;
        if ({bus.i_grant, bus.i_rvalid, bus.mem_address} !== {2'b10, 32'h10})
            $display("FAIL burst_start: grant=%b rvalid=%b addr=%h required 1 0 00000010",
                     bus.i_grant, bus.i_rvalid, bus.mem_address);
        else pass_cnt++;
        for (int b = 0; b < 4; b++) begin
            step();
            if (bus.i_grant === 1'b1) gcnt++;
            total_cnt++;
            if ({bus.i_rvalid, bus.i_done, bus.i_rdata, bus.mem_address} !==
                {1'b1, (b == 3), 32'hA000_0004 + 32'(b), exp_addr[b]})
                $display("FAIL burst_beat%0d: rvalid=%b done=%b rdata=%h addr=%h required 1 %0d %h %h",
                         b, bus.i_rvalid, bus.i_done, bus.i_rdata, bus.mem_address,
                         (b == 3), 32'hA000_0004 + 32'(b), exp_addr[b]);
            else pass_cnt++;
        end
        bus.i_req = 1'b0;
        step();
        total_cnt++;
        if ({bus.i_grant, bus.i_rvalid, bus.i_done, bus.i_rdata} !== {3'b000, 32'hA000_0007})
            $display("FAIL burst_end: grant=%b rvalid=%b done=%b rdata=%h required 0 0 0 a0000007",
                     bus.i_grant, bus.i_rvalid, bus.i_done, bus.i_rdata);
        else pass_cnt++;
        total_cnt++;
        if (gcnt !== 5) $display("FAIL burst_grant_len: cycles=%0d required 5", gcnt);
        else pass_cnt++;
    endtask

    task automatic test_write_then_refill;
        logic [31:0] exp_d [4];
        int          w0;
        exp_d[0] = 32'hDEAD_BEEF; exp_d[1] = 32'hA000_0041;
        exp_d[2] = 32'hA000_0042; exp_d[3] = 32'hA000_0043;
        w0 = wr_cnt;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
        step();
        total_cnt++;
        if ({bus.d_grant, bus.mem_write, bus.mem_address, bus.mem_value, bus.d_done} !==
            {2'b11, 32'h100, 32'hDEAD_BEEF, 1'b0})
            $display("FAIL write_cycle: grant=%b we=%b addr=%h val=%h done=%b required 1 1 00000100 deadbeef 0",
                     bus.d_grant, bus.mem_write, bus.mem_address, bus.mem_value, bus.d_done);
        else pass_cnt++;
        bus.d_wdata = 32'h1234_5678; bus.d_addr = 32'h200;
        step();
        total_cnt++;
        if ({bus.d_done, bus.mem_write, bus.mem_address} !== {2'b10, 32'h0})
            $display("FAIL write_done: done=%b we=%b addr=%h required 1 0 00000000",
                     bus.d_done, bus.mem_write, bus.mem_address);
        else pass_cnt++;
        bus.d_req = 1'b0;
        step();
        total_cnt++;
        if ((wr_cnt - w0) !== 1) $display("FAIL write_once: write cycles=%0d required 1", wr_cnt - w0);
        else pass_cnt++;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h104;
        step();
        total_cnt++;
        if ({bus.d_grant, bus.mem_address} !== {1'b1, 32'h100})
            $display("FAIL refill_start: grant=%b addr=%h required 1 00000100", bus.d_grant, bus.mem_address);
        else pass_cnt++;
        for (int b = 0; b < 4; b++) begin
            step();
            total_cnt++;
            if ({bus.d_rvalid, bus.d_done, bus.d_rdata} !== {1'b1, (b == 3), exp_d[b]})
                $display("FAIL refill_beat%0d: rvalid=%b done=%b rdata=%h required 1 %0d %h",
                         b, bus.d_rvalid, bus.d_done, bus.d_rdata, (b == 3), exp_d[b]);
            else pass_cnt++;
        end
        bus.d_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_burst;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
        repeat (3) step();
        reset = 1'b1; bus.d_req = 1'b0;
        step();
        total_cnt++;
        if ({bus.d_grant, bus.d_rvalid, bus.d_done, bus.mem_address, bus.d_rdata} !== '0)
            $display("FAIL midreset_clear: grant=%b rvalid=%b done=%b addr=%h rdata=%h required all 0",
                     bus.d_grant, bus.d_rvalid, bus.d_done, bus.mem_address, bus.d_rdata);
        else pass_cnt++;
        reset = 1'b0;
        step();
        total_cnt++;
        if ({bus.d_grant, bus.d_rvalid, bus.d_done} !== 3'b000)
            $display("FAIL midreset_quiet: grant=%b rvalid=%b done=%b required 0 0 0",
                     bus.d_grant, bus.d_rvalid, bus.d_done);
        else pass_cnt++;
        bus.i_req = 1'b1; bus.i_addr = 32'h30;
        step();
        for (int b = 0; b < 4; b++) begin
            step();
            total_cnt++;
            if ({bus.i_rvalid, bus.i_done, bus.i_rdata} !== {1'b1, (b == 3), 32'hA000_000C + 32'(b)})
                $display("FAIL midreset_irefill%0d: rvalid=%b done=%b rdata=%h required 1 %0d %h",
                         b, bus.i_rvalid, bus.i_done, bus.i_rdata, (b == 3), 32'hA000_000C + 32'(b));
            else pass_cnt++;
        end
        bus.i_req = 1'b0;
        step();
    endtask

    task automatic test_req_drop;
        int          nrv;
        int          ndn;
        logic [31:0] last;
        nrv = 0; ndn = 0; last = '0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'hC4;
        step();
        bus.d_addr = 32'h200;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.d_rvalid === 1'b1) begin nrv++; last = bus.d_rdata; end
            if (bus.d_done === 1'b1) ndn++;
            if (c == 1) bus.d_req = 1'b0;
        end
        total_cnt++;
        if ({nrv, ndn} !== {32'd4, 32'd1})
            $display("FAIL drop_counts: rvalid=%0d done=%0d required 4 1", nrv, ndn);
        else pass_cnt++;
        total_cnt++;
        if ({bus.d_grant, last} !== {1'b0, 32'hA000_0033})
            $display("FAIL drop_final: grant=%b last rdata=%h required 0 a0000033", bus.d_grant, last);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0; wr_cnt = 0;
        reset = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        test_reset();
        test_contention();
        test_burst();
        test_write_then_refill();
        test_reset_mid_burst();
        test_req_drop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
